bcd_stopwatch_ctrl: RTL and testbench

Two-digit BCD stopwatch/timer controller, downstream of the selectable-rate clock divider.
- Treats the divider's slow clock output as data: synchronises it into the system clock domain and converts each rising edge into a one-cycle tick.
- Counts ticks up or down under a start/pause/clear FSM.
- Drives registered BCD digits to the seven-segment scan stage.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/tick_sync_edge.sv | 27 ++
 rtl/bcd_stopwatch_ctrl.sv | 101 ++++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: FSM state enum, BCD digit type and terminal-value helper for the stopwatch
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    typedef logic [3:0] bcd_t;

    function automatic logic [7:0] bcd_max(input int tens, input int ones);
        bcd_t t;
        bcd_t o;
        t = bcd_t'(tens);
        o = bcd_t'(ones);
        return {t, o};
    endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// tick_sync_edge: synchronises an asynchronous level and emits a one-cycle tick per rising edge
module tick_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // shift the level through the synchroniser and remember its last settled value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign tick = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: two-digit BCD up/down stopwatch with start/pause/clear control; LAP_HOLD_EN adds a lap display freeze
module bcd_stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MAX_TENS    = 5,
    parameter int MAX_ONES    = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic slow_clk_in,
    input  logic start_pause,
    input  logic clear,
    input  logic mode_down,
`ifdef LAP_HOLD_EN
    input  logic lap,
    output logic lap_active,
`endif
    output bcd_t digit_tens,
    output bcd_t digit_ones,
    output logic running,
    output logic done
);

    localparam logic [7:0] MAX_V = bcd_max(MAX_TENS, MAX_ONES);

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx, step_v, start_v, term_v;
    logic       dir_r, dir_nx, tick, hold_nx;

    tick_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (slow_clk_in),
        .tick (tick)
    );

    // next state and next count; clear beats everything, a terminal step beats pause
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dir_nx   = dir_r;
        start_v  = mode_down ? MAX_V : 8'h00;
        term_v   = dir_r ? 8'h00 : MAX_V;
        step_v   = dir_r ? (cnt[3:0] == 4'd0 ? {cnt[7:4] - 4'd1, 4'd9} : {cnt[7:4], cnt[3:0] - 4'd1})
                         : (cnt[3:0] == 4'd9 ? {cnt[7:4] + 4'd1, 4'd0} : {cnt[7:4], cnt[3:0] + 4'd1});
        if (clear) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nx = start_v;
                    if (start_pause) begin
                        state_nx = RUN;
                        dir_nx   = mode_down;
                    end
                end
                RUN: begin
                    if (tick) cnt_nx = step_v;
                    if (tick && step_v == term_v) state_nx = DONE;
                    else if (start_pause) state_nx = PAUSE;
                end
                PAUSE: if (start_pause) state_nx = RUN;
                default: state_nx = DONE;
            endcase
        end
    end

`ifdef LAP_HOLD_EN
    assign hold_nx = state == RUN && state_nx == RUN && (lap ? !lap_active : lap_active);

    // lap freeze flag; dropped whenever RUN is left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lap_active <= 1'b0;
        else lap_active <= hold_nx;
    end
`else
    assign hold_nx = 1'b0;
`endif

    // state, count and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            dir_r      <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
            digit_tens <= '0;
            digit_ones <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            dir_r   <= dir_nx;
            running <= state_nx == RUN;
            done    <= state_nx == DONE;
            if (!hold_nx) {digit_tens, digit_ones} <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// tb_bcd_stopwatch_ctrl: directed plus randomized bench with an integer-valued behavioural model of the stopwatch
module tb_bcd_stopwatch_ctrl;

    localparam int S    = 2;
    localparam int MAXV = 59;

    logic       clk = 0, rst_n = 0, slow_clk_in = 0, start_pause = 0, clear = 0, mode_down = 0;
    logic       lap = 0, lap_active;
    logic [3:0] digit_tens, digit_ones;
    logic       running, done;

    int n_checks = 0, n_errors = 0;

    bcd_stopwatch_ctrl #(.MAX_TENS(5), .MAX_ONES(9), .SYNC_STAGES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .slow_clk_in(slow_clk_in),
        .start_pause(start_pause),
        .clear      (clear),
        .mode_down  (mode_down),
`ifdef LAP_HOLD_EN
        .lap        (lap),
        .lap_active (lap_active),
`endif
        .digit_tens (digit_tens),
        .digit_ones (digit_ones),
        .running    (running),
        .done       (done)
    );

    always #5 clk = ~clk;

    // model: 0 idle, 1 run, 2 pause, 3 done; value kept as a plain integer
    int m_st = 0, m_val = 0, m_disp = 0;
    bit m_dir = 0, m_lapa = 0;
    int hist[0:S];

    initial for (int i = 0; i <= S; i++) hist[i] = 0;

    always @(posedge clk or negedge rst_n) begin
        int nst, nval;
        bit tk, nl;
        if (!rst_n) begin
            m_st = 0; m_val = 0; m_disp = 0; m_dir = 0; m_lapa = 0;
            for (int i = 0; i <= S; i++) hist[i] = 0;
        end else begin
            tk = hist[S-1] != 0 && hist[S] == 0;
            for (int i = S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'(slow_clk_in);
            nst = m_st;
            nval = m_val;
            if (clear) nst = 0;
            else if (m_st == 0) begin
                nval = mode_down ? MAXV : 0;
                if (start_pause) begin nst = 1; m_dir = mode_down; end
            end else if (m_st == 1) begin
                if (tk) nval = m_dir ? m_val - 1 : m_val + 1;
                if (tk && nval == (m_dir ? 0 : MAXV)) nst = 3;
                else if (start_pause) nst = 2;
            end else if (m_st == 2) begin
                if (start_pause) nst = 1;
            end
`ifdef LAP_HOLD_EN
            nl = (m_st == 1 && nst == 1) ? (lap ? !m_lapa : m_lapa) : 1'b0;
`else
            nl = 1'b0;
`endif
            if (!nl) m_disp = nval;
            m_st = nst; m_val = nval; m_lapa = nl;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("model_tens", int'(digit_tens), m_disp / 10);
            check("model_ones", int'(digit_ones), m_disp % 10);
            check("model_running", int'(running), int'(m_st == 1));
            check("model_done", int'(done), int'(m_st == 3));
`ifdef LAP_HOLD_EN
            check("model_lap_active", int'(lap_active), int'(m_lapa));
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sp();
        start_pause = 1; cyc(1); start_pause = 0;
    endtask

    task automatic clr();
        clear = 1; cyc(1); clear = 0; cyc(1);
    endtask

    task automatic edges(input int n);
        repeat (n) begin
            slow_clk_in = 1; cyc(4);
            slow_clk_in = 0; cyc(3);
        end
    endtask

    task automatic lit(input string nm, input int t, input int o, input int r, input int d);
        check({nm, "_tens"}, int'(digit_tens), t);
        check({nm, "_ones"}, int'(digit_ones), o);
        check({nm, "_running"}, int'(running), r);
        check({nm, "_done"}, int'(done), d);
    endtask

    initial begin
        #12;
        lit("reset", 0, 0, 0, 0);
        cyc(1); rst_n = 1; cyc(2);
        // 1: count up ten edges with latency check on the tenth
        sp();
        edges(9);
        slow_clk_in = 1; cyc(S);
        check("latency_pre_ones", int'(digit_ones), 9);
        cyc(1);
        lit("up10", 1, 0, 1, 0);
        cyc(3); slow_clk_in = 0; cyc(3);
        // 2: terminal on the way up
        edges(48);
        lit("up58", 5, 8, 1, 0);
        edges(1);
        lit("up59", 5, 9, 0, 1);
        edges(3); sp(); cyc(2);
        lit("done_hold", 5, 9, 0, 1);
        clr();
        lit("clear_up", 0, 0, 0, 0);
        // 3: count down with borrow
        mode_down = 1; cyc(2);
        lit("down_start", 5, 9, 0, 0);
        sp();
        mode_down = 0;
        edges(9);
        lit("down50", 5, 0, 1, 0);
        edges(1);
        lit("down49", 4, 9, 1, 0);
        edges(49);
        lit("down00", 0, 0, 0, 1);
        clr();
        // 4: tick and start_pause together in RUN
        cyc(1); sp(); edges(7);
        lit("run07", 0, 7, 1, 0);
        slow_clk_in = 1; cyc(S);
        start_pause = 1; cyc(1); start_pause = 0;
        lit("tick_pause", 0, 8, 0, 0);
        cyc(2); slow_clk_in = 0; cyc(3);
        edges(5);
        lit("pause_hold", 0, 8, 0, 0);
        sp();
        check("resume_running", int'(running), 1);
        // 5: clear with tick and start_pause at 23, then async reset
        edges(15);
        lit("run23", 2, 3, 1, 0);
        slow_clk_in = 1; cyc(S);
        clear = 1; start_pause = 1; cyc(1); clear = 0; start_pause = 0; cyc(1);
        lit("clear_wins", 0, 0, 0, 0);
        cyc(2); slow_clk_in = 0; cyc(3);
        sp(); edges(3);
        #2 rst_n = 0;
        #1 lit("async_reset", 0, 0, 0, 0);
        cyc(2); rst_n = 1; cyc(2);
`ifdef LAP_HOLD_EN
        // 6: lap freeze and release
        sp(); edges(12);
        lap = 1; cyc(1); lap = 0;
        edges(3);
        lit("lap_hold", 1, 2, 1, 0);
        check("lap_active_on", int'(lap_active), 1);
        lap = 1; cyc(1); lap = 0;
        lit("lap_release", 1, 5, 1, 0);
        check("lap_active_off", int'(lap_active), 0);
        clr();
`endif
        // randomized phase against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start_pause = $urandom_range(0, 11) == 0;
            clear       = $urandom_range(0, 399) == 0;
            lap         = $urandom_range(0, 19) == 0;
            if ($urandom_range(0, 49) == 0) mode_down = ~mode_down;
            if ($urandom_range(0, 3) == 0) slow_clk_in = ~slow_clk_in;
        end
        start_pause = 0; clear = 0; lap = 0;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
